sat_addsub_pipe: RTL and testbench
==================================

Name: sat_addsub_pipe

Overview:
Parametrised, two-stage pipelined saturating adder/subtractor with an internal accumulator, used by the ALU and the multi-cycle arithmetic path.
Supports any width that is a multiple of the lookahead group, with signed or unsigned saturation selected per operation.
Adds a valid/ready handshake, an accumulate mode and a sticky overflow flag.
Fixed latency of 2 cycles from accept to result.

Parameters:
WIDTH, 16, datapath width in bits; must be a multiple of GROUP and at least 8.
GROUP, 4, carry-lookahead group width; carry ripples between groups.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  block accepts the operation this cycle
op  input  2  00 ADD (a+b); 01 SUB (a-b); 10 ACC (acc+b, written to acc); 11 LOAD (acc<=a, result=a)
uns  input  1  1 = unsigned saturation, 0 = signed saturation
a  input  WIDTH  operand A (ignored for ACC)
b  input  WIDTH  operand B (ignored for LOAD)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
result  output  WIDTH  saturated result
ovf  output  1  saturation occurred for this result
cout  output  1  raw carry out of bit WIDTH-1, taken before saturation
zero  output  1  result == 0
neg  output  1  result[WIDTH-1]
acc  output  WIDTH  current accumulator value
ovf_sticky  output  1  OR of ovf over all results since the last clear
clr_sticky  input  1  clears ovf_sticky

Behaviour:
- Advance signal: adv = ~out_valid | out_ready. in_ready = adv (combinational). An operation is accepted when in_valid & in_ready.
- Stage 1: when adv, s1_valid <= in_valid and the stage captures op/uns/a/b. When adv is low, stage 1 holds.
- Stage 2 (output register): when adv, out_valid <= s1_valid. When s1_valid is set, the output register captures the computed result and flags. When adv is low, all outputs hold stable.
- Latency: an operation accepted at edge N has out_valid=1 after edge N+1, assuming no backpressure. Throughput is 1 operation per cycle.
- Operand selection in stage 2: X = acc for ACC, otherwise s1_a. For SUB the addend is ~s1_b with carry-in 1. ADD and ACC use s1_b with carry-in 0.
- Sum: computed at WIDTH+2 bits.
  - Signed: both operands are sign-extended; saturate to 2^(W-1)-1 when the true result is too large, and to -2^(W-1) when it is too small.
  - Unsigned: ADD/ACC clamp to all-ones when a carry is produced. SUB clamps to 0 when there is a borrow, i.e. when cout=0.
  - ovf = 1 exactly when clamping occurred.
- LOAD: result = s1_a, acc <= s1_a, ovf=0, cout=0.
- acc updates only on adv & s1_valid & (op is ACC or LOAD), on the same edge as the output register. A back-to-back ACC therefore reads the updated acc, so no forwarding hazard exists.
- ACC writes the saturated value to acc.
- zero and neg are computed on the saturated result.
- ovf_sticky <= (ovf_sticky & ~clr_sticky) | (new result captured & its ovf). When a clear and a new overflow occur in the same cycle, the set wins.
- Reset: s1_valid, out_valid, result, ovf, cout, zero, neg, acc and ovf_sticky all go to 0. in_ready = 1 during and after reset.
- Reset mid-operation flushes both stages; no result is emitted for in-flight operations.
- The ready path never depends on in_valid, so there is no combinational loop.

Test Plan:
- WIDTH=16, signed ADD 0x7000+0x2000 -> result 0x7FFF, ovf=1, neg=0, ovf_sticky=1. Signed SUB 0x8000-0x0001 -> 0x8000, ovf=1.
- Unsigned ADD 0xFFF0+0x0020 -> 0xFFFF, cout=1, ovf=1. Unsigned SUB 0x0005-0x0009 -> 0x0000, cout=0, ovf=1, zero=1. Unsigned SUB 0x0009-0x0005 -> 0x0004, cout=1, ovf=0.
- Back-to-back signed sequence: LOAD 0x7FF0, ACC b=0x0008, ACC b=0x0010 on consecutive cycles -> results 0x7FF0, 0x7FF8, 0x7FFF on consecutive cycles; acc=0x7FFF; last ovf=1.
- Backpressure: stream 5 ADDs with out_ready=0 for 3 cycles mid-stream -> in_ready=0 while out_valid & ~out_ready; all 5 results are delivered in order, with no loss or duplication; outputs are stable while stalled.
- Reset with 2 operations in flight -> out_valid=0 and acc=0 on the next cycle; in_ready=1; the next accepted operation emits normally after 2 cycles. clr_sticky in the same cycle as an overflowing result -> ovf_sticky=1.
- WIDTH=8, GROUP=4, signed ADD 0x70+0x20 -> 0x7F, ovf=1. Unsigned ADD 0x70+0x20 -> 0x90, ovf=0.

Source files
------------

// File: rtl/sat_addsub_pipe.sv
// Two-stage pipelined saturating adder/subtractor with accumulator, valid/ready
// handshake and sticky overflow flag. Group carry-lookahead, rippling between groups.
module sat_addsub_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             uns,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic [WIDTH-1:0] acc,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam int unsigned NGRP = WIDTH / GROUP;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    op_e              s1_op_q, s1_op_d;
    logic             s1_uns_q, s1_uns_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;

    // Output stage and architectural state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             sticky_q, sticky_d;

    logic             adv_c;
    logic             is_sub_c;
    logic [WIDTH-1:0] add_x_c, add_y_c, gen_c, prop_c, add_sum_c;
    logic             add_cin_c;
    logic [WIDTH:0]   carry_c;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c, cout_c;

    assign adv_c    = ~out_valid_q | out_ready;
    assign in_ready = adv_c;

    // Operand selection; subtraction is x + ~b + 1
    assign is_sub_c  = (s1_op_q == OP_SUB);
    assign add_x_c   = (s1_op_q == OP_ACC) ? acc_q : s1_a_q;
    assign add_y_c   = is_sub_c ? ~s1_b_q : s1_b_q;
    assign add_cin_c = is_sub_c;
    assign gen_c     = add_x_c & add_y_c;
    assign prop_c    = add_x_c ^ add_y_c;

    // Lookahead carries inside each group, group carry-in taken from the previous group
    always_comb begin : cla
        logic [WIDTH:0] cv;
        logic           gacc;
        logic           pacc;
        cv    = '0;
        cv[0] = add_cin_c;
        gacc  = 1'b0;
        pacc  = 1'b0;
        for (int gi = 0; gi < int'(NGRP); gi++) begin
            for (int k = 0; k < int'(GROUP); k++) begin
                gacc = gen_c[gi*int'(GROUP) + k];
                pacc = prop_c[gi*int'(GROUP) + k];
                for (int j = k - 1; j >= 0; j--) begin
                    gacc = gacc | (pacc & gen_c[gi*int'(GROUP) + j]);
                    pacc = pacc & prop_c[gi*int'(GROUP) + j];
                end
                cv[gi*int'(GROUP) + k + 1] = gacc | (pacc & cv[gi*int'(GROUP)]);
            end
        end
        carry_c = cv;
    end

    assign add_sum_c = prop_c ^ carry_c[WIDTH-1:0];

    // Saturation: signed overflow when carry into and out of the MSB differ
    always_comb begin
        res_c  = add_sum_c;
        ovf_c  = 1'b0;
        cout_c = carry_c[WIDTH];
        if (s1_op_q == OP_LOAD) begin
            res_c  = s1_a_q;
            cout_c = 1'b0;
        end else if (s1_uns_q) begin
            if (is_sub_c && !carry_c[WIDTH]) begin
                res_c = '0;
                ovf_c = 1'b1;
            end else if (!is_sub_c && carry_c[WIDTH]) begin
                res_c = '1;
                ovf_c = 1'b1;
            end
        end else if (carry_c[WIDTH] ^ carry_c[WIDTH-1]) begin
            res_c = add_x_c[WIDTH-1] ? SMIN : SMAX;
            ovf_c = 1'b1;
        end
    end

    // Pipeline advance, accumulator and sticky flag next-state
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_uns_d    = s1_uns_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q & ~clr_sticky;
        if (adv_c) begin
            s1_valid_d  = in_valid;
            s1_op_d     = op_e'(op);
            s1_uns_d    = uns;
            s1_a_d      = a;
            s1_b_d      = b;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = res_c;
                ovf_d    = ovf_c;
                cout_d   = cout_c;
                zero_d   = (res_c == '0);
                neg_d    = res_c[WIDTH-1];
                if (s1_op_q == OP_ACC || s1_op_q == OP_LOAD) begin
                    acc_d = res_c;
                end
                if (ovf_c) begin
                    sticky_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_uns_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_uns_q    <= s1_uns_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign ovf        = ovf_q;
    assign cout       = cout_q;
    assign zero       = zero_q;
    assign neg        = neg_q;
    assign acc        = acc_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Directed bench for sat_addsub_pipe: 16-bit instance for the main sequence,
// 8-bit instance for the narrow-width saturation cases.
module tb_sat_addsub_pipe;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ACC = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, uns, out_valid, out_ready;
    logic        ovf, cout, zero, neg, ovf_sticky, clr_sticky;
    logic [1:0]  op;
    logic [15:0] a, b, result, acc;

    logic        in_valid8, in_ready8, uns8, out_valid8, out_ready8;
    logic        ovf8, cout8, zero8, neg8, ovf_sticky8, clr_sticky8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, result8, acc8;

    int checks = 0;
    int failures = 0;

    sat_addsub_pipe #(.WIDTH(16), .GROUP(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .uns(uns),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ovf(ovf), .cout(cout), .zero(zero), .neg(neg), .acc(acc),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
    );

    sat_addsub_pipe #(.WIDTH(8), .GROUP(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .uns(uns8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .ovf(ovf8), .cout(cout8), .zero(zero8), .neg(neg8), .acc(acc8),
        .ovf_sticky(ovf_sticky8), .clr_sticky(clr_sticky8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one op for one cycle, then wait for its result slot (called just after an edge)
    task automatic op16(input logic [1:0] o, input logic u, input logic [15:0] aa, input logic [15:0] bb);
        in_valid = 1'b1; op = o; uns = u; a = aa; b = bb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic op8_run(input logic [1:0] o, input logic u, input logic [7:0] aa, input logic [7:0] bb);
        in_valid8 = 1'b1; op8 = o; uns8 = u; a8 = aa; b8 = bb;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [15:0] exp_q[$];
    int sent, rcvd, stall_seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = ADD; uns = 1'b0; a = '0; b = '0;
        out_ready = 1'b1; clr_sticky = 1'b0;
        in_valid8 = 1'b0; op8 = ADD; uns8 = 1'b0; a8 = '0; b8 = '0;
        out_ready8 = 1'b1; clr_sticky8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_sticky", 32'(ovf_sticky), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Signed ADD overflow to +max
        op16(ADD, 1'b0, 16'h7000, 16'h2000);
        chk("sadd_valid", 32'(out_valid), 32'd1);
        chk("sadd_result", 32'(result), 32'h7FFF);
        chk("sadd_ovf", 32'(ovf), 32'd1);
        chk("sadd_neg", 32'(neg), 32'd0);
        chk("sadd_cout", 32'(cout), 32'd0);
        chk("sadd_sticky", 32'(ovf_sticky), 32'd1);

        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        chk("clr_sticky", 32'(ovf_sticky), 32'd0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Signed SUB underflow to -max
        op16(SUB, 1'b0, 16'h8000, 16'h0001);
        chk("ssub_result", 32'(result), 32'h8000);
        chk("ssub_ovf", 32'(ovf), 32'd1);
        chk("ssub_neg", 32'(neg), 32'd1);

        op16(ADD, 1'b1, 16'hFFF0, 16'h0020);
        chk("uadd_result", 32'(result), 32'hFFFF);
        chk("uadd_cout", 32'(cout), 32'd1);
        chk("uadd_ovf", 32'(ovf), 32'd1);

        op16(SUB, 1'b1, 16'h0005, 16'h0009);
        chk("usub_borrow_result", 32'(result), 32'h0000);
        chk("usub_borrow_cout", 32'(cout), 32'd0);
        chk("usub_borrow_ovf", 32'(ovf), 32'd1);
        chk("usub_borrow_zero", 32'(zero), 32'd1);

        op16(SUB, 1'b1, 16'h0009, 16'h0005);
        chk("usub_result", 32'(result), 32'h0004);
        chk("usub_cout", 32'(cout), 32'd1);
        chk("usub_ovf", 32'(ovf), 32'd0);
        chk("usub_zero", 32'(zero), 32'd0);

        // Back-to-back LOAD, ACC, ACC
        in_valid = 1'b1; uns = 1'b0; op = LOAD; a = 16'h7FF0; b = 16'h0000;
        @(posedge clk); #1;
        op = ACC; a = 16'h1234; b = 16'h0008;
        @(posedge clk); #1;
        chk("b2b_load_valid", 32'(out_valid), 32'd1);
        chk("b2b_load_result", 32'(result), 32'h7FF0);
        chk("b2b_load_cout", 32'(cout), 32'd0);
        chk("b2b_load_acc", 32'(acc), 32'h7FF0);
        op = ACC; b = 16'h0010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_acc1_result", 32'(result), 32'h7FF8);
        chk("b2b_acc1_ovf", 32'(ovf), 32'd0);
        chk("b2b_acc1_acc", 32'(acc), 32'h7FF8);
        @(posedge clk); #1;
        chk("b2b_acc2_valid", 32'(out_valid), 32'd1);
        chk("b2b_acc2_result", 32'(result), 32'h7FFF);
        chk("b2b_acc2_ovf", 32'(ovf), 32'd1);
        chk("b2b_acc2_acc", 32'(acc), 32'h7FFF);
        @(posedge clk); #1;

        // Backpressure: 5 unsigned ADDs with out_ready low for 3 cycles
        sent = 0; rcvd = 0; stall_seen = 0;
        for (int cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
            in_valid = (sent < 5); op = ADD; uns = 1'b1;
            a = 16'(sent * 256 + 1); b = 16'h0010;
            out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (!out_ready) begin
                stall_seen++;
                chk("bp_stall_valid", 32'(out_valid), 32'd1);
                chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_valid) begin
                if (exp_q.size() > 0) chk("bp_result", 32'(result), 32'(exp_q[0]));
                else chk("bp_unexpected_output", 32'(out_valid), 32'd0);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(a + b);
                sent++;
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                rcvd++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_delivered", 32'(rcvd), 32'd5);
        chk("bp_stall_cycles", 32'(stall_seen), 32'd3);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        // Reset with two operations in flight
        in_valid = 1'b1; op = ADD; uns = 1'b0; a = 16'h0001; b = 16'h0001;
        @(posedge clk); #1;
        a = 16'h0002; b = 16'h0002;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_acc", 32'(acc), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_sticky", 32'(ovf_sticky), 32'd0);
        @(posedge clk); #1;
        chk("flush_no_leak", 32'(out_valid), 32'd0);
        in_valid = 1'b1; op = ADD; uns = 1'b0; a = 16'h0001; b = 16'h0002;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_not_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_result", 32'(result), 32'h0003);

        // Clear coinciding with an overflowing result: set wins
        in_valid = 1'b1; op = ADD; uns = 1'b0; a = 16'h7000; b = 16'h2000;
        @(posedge clk); #1;
        in_valid = 1'b0; clr_sticky = 1'b1;
        @(posedge clk); #1;
        chk("clr_vs_set_ovf", 32'(ovf), 32'd1);
        chk("clr_vs_set_sticky", 32'(ovf_sticky), 32'd1);
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        chk("clr_after", 32'(ovf_sticky), 32'd0);

        // 8-bit instance
        op8_run(ADD, 1'b0, 8'h70, 8'h20);
        chk("w8_sadd_result", 32'(result8), 32'h7F);
        chk("w8_sadd_ovf", 32'(ovf8), 32'd1);
        op8_run(ADD, 1'b1, 8'h70, 8'h20);
        chk("w8_uadd_result", 32'(result8), 32'h90);
        chk("w8_uadd_ovf", 32'(ovf8), 32'd0);
        chk("w8_uadd_neg", 32'(neg8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
